// File: rtl/clock_div_meter_pkg.sv
// Shared types and defaults for the clock division meter.
package clock_div_meter_pkg;

  localparam int unsigned DefaultWidth     = 32;
  localparam int unsigned DefaultTimeout   = 1000000;
  localparam int unsigned DefaultLockCount = 4;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StMeasure
  } state_e;

  // Bits needed to hold a match count of 0..lock_count.
  function automatic int unsigned match_width(input int unsigned lock_count);
    return $clog2(lock_count + 1);
  endfunction

endpackage

// File: rtl/clock_div_meter_if.sv
// Measurement-side signal bundle for clock_div_meter.
// div_min/div_max exist only when CLKDIV_METER_MINMAX_EN is defined.
interface clock_div_meter_if
  import clock_div_meter_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) ();

  logic             clk_in;
  logic             enable;
  logic [WIDTH-1:0] div_fact;
  logic             meas_valid;
  logic             locked;
  logic             timeout;
`ifdef CLKDIV_METER_MINMAX_EN
  logic [WIDTH-1:0] div_min;
  logic [WIDTH-1:0] div_max;
`endif

  modport master (
    output clk_in, enable,
    input  div_fact, meas_valid, locked, timeout
`ifdef CLKDIV_METER_MINMAX_EN
    , input div_min, div_max
`endif
  );

  modport slave (
    input  clk_in, enable,
    output div_fact, meas_valid, locked, timeout
`ifdef CLKDIV_METER_MINMAX_EN
    , output div_min, div_max
`endif
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Three-flop synchronizer with a both-edges pulse on the synchronized input.
// The pulse port is edge_det because "edge" is a reserved word.
module sync_edge_detect (
  input  logic clk_ref,
  input  logic rst,
  input  logic d,
  output logic edge_det
);

  logic sync1_q, sync2_q, sync3_q;

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign edge_det = sync2_q ^ sync3_q;

endmodule

// File: rtl/clock_div_meter.sv
// Measures clk_in half-period in clk_ref cycles, with lock and loss detection.
// Define CLKDIV_METER_MINMAX_EN to add div_min/div_max tracking.
module clock_div_meter
  import clock_div_meter_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter int unsigned TIMEOUT    = DefaultTimeout,
  parameter int unsigned LOCK_COUNT = DefaultLockCount
) (
  input logic              clk_ref,
  input logic              rst,
  clock_div_meter_if.slave bus
);

  localparam int unsigned      MatchW   = match_width(LOCK_COUNT);
  localparam logic [WIDTH-1:0] TimeoutW = WIDTH'(TIMEOUT);
  localparam logic [MatchW-1:0] LockW   = MatchW'(LOCK_COUNT);

  state_e            state_q;
  logic [WIDTH-1:0]  cnt_q, cnt_next;
  logic [MatchW-1:0] match_q, match_next;
  logic [WIDTH-1:0]  div_fact_q;
  logic              meas_valid_q, locked_q, timeout_q;
  logic              clk_edge, cnt_sat;
`ifdef CLKDIV_METER_MINMAX_EN
  logic [WIDTH-1:0]  div_min_q, div_max_q;
`endif

  sync_edge_detect u_sync_edge_detect (
    .clk_ref  (clk_ref),
    .rst      (rst),
    .d        (bus.clk_in),
    .edge_det (clk_edge)
  );

  always_comb begin
    cnt_sat  = (cnt_q == TimeoutW);
    cnt_next = cnt_q;
    if (clk_edge) begin
      cnt_next = WIDTH'(1);
    end else if (!cnt_sat) begin
      cnt_next = cnt_q + WIDTH'(1);
    end
    match_next = MatchW'(1);
    if (cnt_q == div_fact_q) begin
      match_next = (match_q == LockW) ? match_q : match_q + MatchW'(1);
    end
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      match_q      <= '0;
      div_fact_q   <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef CLKDIV_METER_MINMAX_EN
      div_min_q    <= '1;
      div_max_q    <= '0;
`endif
    end else begin
      meas_valid_q <= 1'b0;
      // Dropping enable beats any coincident edge; div_fact is kept.
      if (!bus.enable) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        match_q   <= '0;
        locked_q  <= 1'b0;
        timeout_q <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            state_q <= StArm;
            cnt_q   <= '0;
`ifdef CLKDIV_METER_MINMAX_EN
            div_min_q <= '1;
            div_max_q <= '0;
`endif
          end
          StArm: begin
            cnt_q <= cnt_next;
            if (clk_edge) begin
              state_q   <= StMeasure;
              timeout_q <= 1'b0;
            end else if (cnt_sat) begin
              timeout_q <= 1'b1;
            end
          end
          StMeasure: begin
            cnt_q <= cnt_next;
            // An edge landing on a saturated count is still a measurement.
            if (clk_edge) begin
              div_fact_q   <= cnt_q;
              meas_valid_q <= 1'b1;
              match_q      <= match_next;
              locked_q     <= (match_next == LockW);
`ifdef CLKDIV_METER_MINMAX_EN
              if (cnt_q < div_min_q) div_min_q <= cnt_q;
              if (cnt_q > div_max_q) div_max_q <= cnt_q;
`endif
            end else if (cnt_sat) begin
              state_q   <= StArm;
              timeout_q <= 1'b1;
              locked_q  <= 1'b0;
              match_q   <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.div_fact   = div_fact_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.locked     = locked_q;
  assign bus.timeout    = timeout_q;
`ifdef CLKDIV_METER_MINMAX_EN
  assign bus.div_min    = div_min_q;
  assign bus.div_max    = div_max_q;
`endif

endmodule

// File: tb/tb_clock_div_meter.sv
// Directed bench for clock_div_meter (TIMEOUT=100, LOCK_COUNT=4).
// Min/max checks run when CLKDIV_METER_MINMAX_EN is defined.
module tb_clock_div_meter;

  logic clk_ref;
  logic rst;
  int   errors;
  int   checks;

  logic [31:0] mv_fact[$];
  logic        mv_lock[$];

  clock_div_meter_if #(.WIDTH(32)) bus ();

  clock_div_meter #(
    .WIDTH      (32),
    .TIMEOUT    (100),
    .LOCK_COUNT (4)
  ) dut (
    .clk_ref (clk_ref),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  // One clk_ref cycle; outputs are sampled 1ns after the edge and every
  // meas_valid pulse is logged with the div_fact/locked seen alongside it.
  task automatic sample_tick();
    @(posedge clk_ref);
    #1;
    if (bus.meas_valid === 1'b1) begin
      mv_fact.push_back(bus.div_fact);
      mv_lock.push_back(bus.locked);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) sample_tick();
  endtask

  task automatic run_toggles(input int d, input int ntog, input int tail);
    for (int i = 0; i < ntog; i++) begin
      bus.clk_in = ~bus.clk_in;
      ticks(d);
    end
    ticks(tail);
  endtask

  task automatic clear_log();
    mv_fact.delete();
    mv_lock.delete();
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.clk_in = 1'b0;
    ticks(3);
    checks++;
    if (bus.div_fact !== 32'd0) begin
      errors++; $display("FAIL reset_div_fact: got %0d want 0", bus.div_fact);
    end
    checks++;
    if (bus.meas_valid !== 1'b0) begin
      errors++; $display("FAIL reset_meas_valid: got %b want 0", bus.meas_valid);
    end
    checks++;
    if (bus.locked !== 1'b0) begin
      errors++; $display("FAIL reset_locked: got %b want 0", bus.locked);
    end
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++; $display("FAIL reset_timeout: got %b want 0", bus.timeout);
    end
    rst = 1'b0;
    ticks(2);
  endtask

  // D=5 to lock, then D=7: the switch must drop lock and relock on the 4th 7.
  task automatic test_lock_and_change();
    int exp_fact [10] = '{5, 5, 5, 5, 5, 5, 7, 7, 7, 7};
    bit exp_lock [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
    bus.enable = 1'b1;
    ticks(1);
    clear_log();
    run_toggles(5, 6, 0);
    checks++;
    if (mv_fact.size() != 5) begin
      errors++; $display("FAIL d5_meas_count: got %0d want 5", mv_fact.size());
    end
    run_toggles(7, 5, 0);
    checks++;
    if (mv_fact.size() != 10) begin
      errors++; $display("FAIL change_meas_count: got %0d want 10", mv_fact.size());
    end
    for (int i = 0; i < 10 && i < mv_fact.size(); i++) begin
      checks++;
      if (mv_fact[i] !== 32'(exp_fact[i])) begin
        errors++; $display("FAIL lock_div_fact[%0d]: got %0d want %0d", i, mv_fact[i], exp_fact[i]);
      end
      checks++;
      if (mv_lock[i] !== exp_lock[i]) begin
        errors++; $display("FAIL lock_locked[%0d]: got %b want %b", i, mv_lock[i], exp_lock[i]);
      end
    end
  endtask

  // Last edge was consumed 4 cycles ago; timeout lands exactly 100 cycles after it.
  task automatic test_timeout();
    int exp_lock [4] = '{0, 0, 0, 1};
    clear_log();
    ticks(95);
    checks++;
    if (bus.timeout !== 1'b0 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: got timeout=%b locked=%b want 0 1", bus.timeout, bus.locked);
    end
    ticks(1);
    checks++;
    if (bus.timeout !== 1'b1 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL timeout_hit: got timeout=%b locked=%b want 1 0", bus.timeout, bus.locked);
    end
    ticks(20);
    checks++;
    if (bus.timeout !== 1'b1 || bus.div_fact !== 32'd7) begin
      errors++;
      $display("FAIL timeout_hold: got timeout=%b div_fact=%0d want 1 7", bus.timeout, bus.div_fact);
    end
    bus.clk_in = ~bus.clk_in;
    ticks(2);
    checks++;
    if (bus.timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_pre_edge: got %b want 1", bus.timeout);
    end
    ticks(1);
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: got %b want 0", bus.timeout);
    end
    checks++;
    if (mv_fact.size() != 0) begin
      errors++; $display("FAIL timeout_no_meas: got %0d pulses want 0", mv_fact.size());
    end
    ticks(3);
    run_toggles(6, 4, 0);
    checks++;
    if (mv_fact.size() != 4) begin
      errors++; $display("FAIL relock_count: got %0d want 4", mv_fact.size());
    end
    for (int i = 0; i < 4 && i < mv_fact.size(); i++) begin
      checks++;
      if (mv_fact[i] !== 32'd6 || mv_lock[i] !== exp_lock[i][0]) begin
        errors++;
        $display("FAIL relock[%0d]: got %0d/%b want 6/%0d", i, mv_fact[i], mv_lock[i], exp_lock[i]);
      end
    end
  endtask

  task automatic test_disable_and_reset();
    clear_log();
    bus.clk_in = ~bus.clk_in;
    ticks(2);
    bus.enable = 1'b0;
    ticks(1);
    checks++;
    if (bus.meas_valid !== 1'b0 || bus.locked !== 1'b0 || bus.div_fact !== 32'd6) begin
      errors++;
      $display("FAIL disable_edge: got mv=%b locked=%b div_fact=%0d want 0 0 6",
               bus.meas_valid, bus.locked, bus.div_fact);
    end
    ticks(4);
    checks++;
    if (mv_fact.size() != 0) begin
      errors++; $display("FAIL disable_no_meas: got %0d pulses want 0", mv_fact.size());
    end
    bus.enable = 1'b1;
    ticks(1);
    bus.clk_in = ~bus.clk_in;
    ticks(5);
    rst = 1'b1;
    ticks(1);
    checks++;
    if (bus.div_fact !== 32'd0 || bus.meas_valid !== 1'b0 || bus.locked !== 1'b0 ||
        bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got div_fact=%0d mv=%b locked=%b timeout=%b want 0 0 0 0",
               bus.div_fact, bus.meas_valid, bus.locked, bus.timeout);
    end
    bus.enable = 1'b0;
    ticks(1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.clk_in = ~bus.clk_in;
      ticks(2);
    end
    ticks(4);
    checks++;
    if (mv_fact.size() != 0 || bus.div_fact !== 32'd0) begin
      errors++;
      $display("FAIL idle_ignores_edges: got %0d pulses div_fact=%0d want 0 0",
               mv_fact.size(), bus.div_fact);
    end
  endtask

  task automatic test_d1();
    bit exp_lock [7] = '{0, 0, 0, 1, 1, 1, 1};
    bus.enable = 1'b1;
    ticks(1);
    clear_log();
    run_toggles(1, 8, 4);
    checks++;
    if (mv_fact.size() != 7) begin
      errors++; $display("FAIL d1_meas_count: got %0d want 7", mv_fact.size());
    end
    for (int i = 0; i < 7 && i < mv_fact.size(); i++) begin
      checks++;
      if (mv_fact[i] !== 32'd1 || mv_lock[i] !== exp_lock[i]) begin
        errors++;
        $display("FAIL d1[%0d]: got %0d/%b want 1/%b", i, mv_fact[i], mv_lock[i], exp_lock[i]);
      end
    end
    bus.enable = 1'b0;
    ticks(2);
  endtask

`ifdef CLKDIV_METER_MINMAX_EN
  task automatic test_minmax();
    bus.enable = 1'b1;
    ticks(1);
    checks++;
    if (bus.div_min !== 32'hffff_ffff || bus.div_max !== 32'd0) begin
      errors++;
      $display("FAIL minmax_reinit: got min=%0h max=%0d want ffffffff 0", bus.div_min, bus.div_max);
    end
    clear_log();
    for (int i = 0; i < 6; i++) begin
      bus.clk_in = ~bus.clk_in;
      ticks((i % 2 == 0) ? 3 : 9);
    end
    checks++;
    if (mv_fact.size() != 5) begin
      errors++; $display("FAIL minmax_count: got %0d want 5", mv_fact.size());
    end
    checks++;
    if (bus.div_min !== 32'd3 || bus.div_max !== 32'd9 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL minmax_values: got min=%0d max=%0d locked=%b want 3 9 0",
               bus.div_min, bus.div_max, bus.locked);
    end
  endtask
`endif

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.clk_in = 1'b0;
    test_reset();
    test_lock_and_change();
    test_timeout();
    test_disable_and_reset();
    test_d1();
`ifdef CLKDIV_METER_MINMAX_EN
    test_minmax();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
